// File: rtl/branch_predictor_table.sv
// Table of per-entry branch-direction counters with a registered lookup port,
// an update port and a clear sweep. Optional stats counters under BPT_STATS_EN.

module bpt_entry #(
    parameter int              CTR_W = 2,
    parameter logic [CTR_W-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CTR_W-1:0] wr_data,
    output logic [CTR_W-1:0] state
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state <= INIT;
        else if (wr_en) state <= wr_data;
    end
endmodule

module branch_predictor_table #(
    parameter int ENTRIES  = 64,
    parameter int INDEX_W  = $clog2(ENTRIES),
    parameter int CTR_W    = 2,
    parameter int MODIFIED = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lookup_valid,
    input  logic [INDEX_W-1:0] lookup_index,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [CTR_W-1:0]   pred_state,
    input  logic               update_valid,
    input  logic [INDEX_W-1:0] update_index,
    input  logic               update_taken,
    input  logic               clear_req,
    output logic               busy
`ifdef BPT_STATS_EN
    ,
    output logic [15:0]        stat_updates,
    output logic [15:0]        stat_flips
`endif
);
    localparam logic [CTR_W-1:0]   CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]   CTR_HALF = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0]   CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ENTRIES - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                          fsm;
    logic [INDEX_W-1:0]              ptr;
    logic [ENTRIES-1:0][CTR_W-1:0]   ctr_q;
    logic [ENTRIES-1:0]              wr_en;
    logic [CTR_W-1:0]                wr_data;
    logic [CTR_W-1:0]                upd_cur, upd_nxt, lk_data;
    logic                            upd_wr, lk_acc, clr_wr;

    function automatic logic [CTR_W-1:0] next_ctr(input logic [CTR_W-1:0] c, input logic taken);
        logic [CTR_W-1:0] n;
        if (MODIFIED != 0) begin
            if (taken) n = (c == '0) ? CTR_HALF : CTR_MAX;
            else       n = (c == CTR_MAX) ? CTR_INIT : '0;
        end else begin
            if (taken) n = (c == CTR_MAX) ? c : c + 1'b1;
            else       n = (c == '0) ? c : c - 1'b1;
        end
        return n;
    endfunction

    assign clr_wr  = (fsm == CLEAR);
    assign upd_wr  = update_valid && (fsm == IDLE);
    assign lk_acc  = lookup_valid && (fsm == IDLE);
    assign upd_cur = ctr_q[update_index];
    assign upd_nxt = next_ctr(upd_cur, update_taken);
    assign wr_data = clr_wr ? CTR_INIT : upd_nxt;
    // Write-through: a same-index update in this cycle is visible to the lookup.
    assign lk_data = (upd_wr && (update_index == lookup_index)) ? upd_nxt : ctr_q[lookup_index];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        assign wr_en[i] = (clr_wr && (ptr == INDEX_W'(i))) ||
                          (upd_wr && (update_index == INDEX_W'(i)));
        bpt_entry #(.CTR_W(CTR_W), .INIT(CTR_INIT)) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[i]),
            .wr_data (wr_data),
            .state   (ctr_q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm  <= IDLE;
            ptr  <= '0;
            busy <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (clear_req) begin
                        fsm  <= CLEAR;
                        ptr  <= '0;
                        busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST_IDX) begin
                        fsm  <= IDLE;
                        ptr  <= '0;
                        busy <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_state <= CTR_INIT;
        end else begin
            pred_valid <= lk_acc;
            if (lk_acc) begin
                pred_state <= lk_data;
                pred_taken <= lk_data[CTR_W-1];
            end
        end
    end

`ifdef BPT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_updates <= '0;
            stat_flips   <= '0;
        end else if (upd_wr) begin
            if (stat_updates != 16'hFFFF) stat_updates <= stat_updates + 16'd1;
            if ((upd_nxt[CTR_W-1] != upd_cur[CTR_W-1]) && (stat_flips != 16'hFFFF))
                stat_flips <= stat_flips + 16'd1;
        end
    end
`endif

endmodule
